adder_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit that generalises the fixed-width ripple adders to any WIDTH.
- Splits the operation into STAGES equal slices; each stage adds one slice and registers the slice carry to the next stage.
- Adds a valid/ready stream handshake with backpressure, a subtract mode and a signed-overflow flag.
- Used wherever wide arithmetic must close timing at full clock rate.

---
 rtl/adder_pipe.sv | 126 ++++++++++++
 tb/tb_adder_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract unit: one SW-bit slice per stage, carries registered
// between stages, valid/ready handshake with a single global advance enable.
module adder_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din_one,
   input  logic [WIDTH-1:0] din_two,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = WIDTH / STAGES;

   if (WIDTH % STAGES != 0) begin : g_bad_width
      $error("adder_pipe: WIDTH must be a multiple of STAGES");
   end

   function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y,
                                             input logic          ci);
      return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
   endfunction

   // a^b^s at the MSB recovers the carry into the MSB; xor with carry-out gives overflow
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb, input logic c_out);
      return a_msb ^ b_msb ^ s_msb ^ c_out;
   endfunction

   logic             adv;
   logic [WIDTH-1:0] stg_a [STAGES];
   logic [WIDTH-1:0] stg_b [STAGES];
   logic [WIDTH-1:0] stg_s [STAGES];
   logic             stg_c [STAGES];
   logic             stg_v [STAGES];
   logic [SW:0]      slice_r;

   logic [WIDTH-1:0] opa_d [STAGES];
   logic [WIDTH-1:0] opa_q [STAGES];
   logic [WIDTH-1:0] opb_d [STAGES];
   logic [WIDTH-1:0] opb_q [STAGES];
   logic [WIDTH-1:0] sum_d [STAGES];
   logic [WIDTH-1:0] sum_q [STAGES];
   logic [STAGES-1:0] cry_d, cry_q;
   logic [STAGES-1:0] vld_d, vld_q;
   logic             ovf_d, ovf_q;

   always_comb begin
      adv     = ~vld_q[STAGES-1] | out_ready;
      slice_r = '0;
      cry_d   = '0;
      vld_d   = '0;

      // entry conditioning: subtraction becomes A + ~B + ~cin
      stg_a[0] = din_one;
      stg_b[0] = sub ? ~din_two : din_two;
      stg_c[0] = sub ? ~cin : cin;
      stg_s[0] = '0;
      stg_v[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         stg_a[k] = opa_q[k-1];
         stg_b[k] = opb_q[k-1];
         stg_c[k] = cry_q[k-1];
         stg_s[k] = sum_q[k-1];
         stg_v[k] = vld_q[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         slice_r  = slice_add(stg_a[k][k*SW +: SW], stg_b[k][k*SW +: SW], stg_c[k]);
         opa_d[k] = stg_a[k];
         opb_d[k] = stg_b[k];
         sum_d[k] = stg_s[k];
         sum_d[k][k*SW +: SW] = slice_r[SW-1:0];
         cry_d[k] = slice_r[SW];
         vld_d[k] = stg_v[k];
      end

      ovf_d = signed_ovf(opa_d[STAGES-1][WIDTH-1], opb_d[STAGES-1][WIDTH-1],
                         sum_d[STAGES-1][WIDTH-1], cry_d[STAGES-1]);
   end

   // every stage register moves together on adv, so stalls freeze carries and bubbles alike
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         cry_q <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= '0;
         end
      end else if (adv) begin
         vld_q <= vld_d;
         cry_q <= cry_d;
         ovf_q <= ovf_d;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= sum_d[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
         end
      end
   end

   assign in_ready  = adv;
   assign out_valid = vld_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = cry_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: three instances (32b/4 stages, 64b/1 stage, 64b/8 stages),
// directed vector table plus randomized streaming against an arithmetic reference model.
module tb_adder_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic        cin;
   logic        sub;
   logic [63:0] din_one;
   logic [63:0] din_two;
   int          sel;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   bit          rand_rdy = 0;
   bit          chk_lat = 0;
   int          pop_cnt = 0;
   int          pop_first = 0;
   int          pop_last = 0;

   logic        iv_a, iv_b, iv_c;
   logic        rdy_a, rdy_b, rdy_c;
   logic        ov_a, ov_b, ov_c;
   logic        co_a, co_b, co_c;
   logic        of_a, of_b, of_c;
   logic [31:0] sum_a;
   logic [63:0] sum_b, sum_c;

   logic        cur_in_ready, cur_ov, cur_co, cur_of;
   logic [63:0] cur_sum;

   assign iv_a = in_valid && (sel == 0);
   assign iv_b = in_valid && (sel == 1);
   assign iv_c = in_valid && (sel == 2);

   adder_pipe #(.WIDTH(32), .STAGES(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(rdy_a),
      .din_one(din_one[31:0]), .din_two(din_two[31:0]), .cin(cin), .sub(sub),
      .out_valid(ov_a), .out_ready(out_ready), .sum(sum_a), .cout(co_a), .ovf(of_a));

   adder_pipe #(.WIDTH(64), .STAGES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(rdy_b),
      .din_one(din_one), .din_two(din_two), .cin(cin), .sub(sub),
      .out_valid(ov_b), .out_ready(out_ready), .sum(sum_b), .cout(co_b), .ovf(of_b));

   adder_pipe #(.WIDTH(64), .STAGES(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(rdy_c),
      .din_one(din_one), .din_two(din_two), .cin(cin), .sub(sub),
      .out_valid(ov_c), .out_ready(out_ready), .sum(sum_c), .cout(co_c), .ovf(of_c));

   always_comb begin
      cur_in_ready = rdy_a;
      cur_ov       = ov_a;
      cur_sum      = {32'd0, sum_a};
      cur_co       = co_a;
      cur_of       = of_a;
      if (sel == 1) begin
         cur_in_ready = rdy_b; cur_ov = ov_b; cur_sum = sum_b; cur_co = co_b; cur_of = of_b;
      end else if (sel == 2) begin
         cur_in_ready = rdy_c; cur_ov = ov_c; cur_sum = sum_c; cur_co = co_c; cur_of = of_c;
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (sel %0d, cycle %0d)", nm, act, exp, sel, cyc);
   endtask

   function automatic int width_of(input int s);
      return (s == 0) ? 32 : 64;
   endfunction

   function automatic int stages_of(input int s);
      return (s == 0) ? 4 : ((s == 1) ? 1 : 8);
   endfunction

   // Plain-arithmetic reference: unsigned result mod 2^w, carry/no-borrow, signed range test
   task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s,
                        output logic [63:0] r, output logic co, output logic ov);
      logic [63:0] mask;
      logic [127:0] ua, ub, ur;
      logic signed [127:0] sa, sb, sr, maxv, minv;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      ua = {64'd0, a & mask};
      ub = {64'd0, b & mask};
      sa = $signed(ua) - (a[w-1] ? (128'sd1 <<< w) : 128'sd0);
      sb = $signed(ub) - (b[w-1] ? (128'sd1 <<< w) : 128'sd0);
      if (!s) begin
         ur = ua + ub + {127'd0, c};
         co = ur[w];
         sr = sa + sb + $signed({127'd0, c});
      end else begin
         co = (ua >= ub + {127'd0, c});
         ur = ua - ub - {127'd0, c};
         sr = sa - sb - $signed({127'd0, c});
      end
      r    = ur[63:0] & mask;
      maxv = (128'sd1 <<< (w - 1)) - 128'sd1;
      minv = -(128'sd1 <<< (w - 1));
      ov   = (sr > maxv) || (sr < minv);
   endtask

   typedef struct {
      logic [63:0] s;
      logic        c;
      logic        o;
      int          acc;
   } exp_t;

   exp_t        q[$];
   bit          prev_stall = 0;
   int          prev_sel = 0;
   logic [63:0] prev_sum;
   logic        prev_co, prev_of;

   // Scoreboard: decides at the negedge what the coming posedge will accept and pop
   always @(negedge clk) begin : monitor
      exp_t e;
      logic [63:0] r;
      logic co, ov;
      if (!rst_n) begin
         q.delete();
         prev_stall = 0;
      end else begin
         chk("in_ready_rule", cur_in_ready, !cur_ov || out_ready);
         if (prev_stall && prev_sel == sel) begin
            chk("hold_valid", cur_ov, 1);
            chk("hold_sum", cur_sum, prev_sum);
            chk("hold_cout", cur_co, prev_co);
            chk("hold_ovf", cur_of, prev_of);
         end
         if (cur_ov && out_ready) begin
            chk("result_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("model_sum", cur_sum, e.s);
               chk("model_cout", cur_co, e.c);
               chk("model_ovf", cur_of, e.o);
               if (chk_lat) chk("latency", cyc - e.acc, stages_of(sel) - 1);
            end
            if (pop_cnt == 0) pop_first = cyc;
            pop_last = cyc;
            pop_cnt++;
         end
         if (in_valid && cur_in_ready) begin
            model(width_of(sel), din_one, din_two, cin, sub, r, co, ov);
            e.s = r; e.c = co; e.o = ov; e.acc = cyc + 1;
            q.push_back(e);
         end
         prev_stall = cur_ov && !out_ready;
         prev_sel   = sel;
         prev_sum   = cur_sum;
         prev_co    = cur_co;
         prev_of    = cur_of;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
      bit acc;
      int waited;
      din_one = a; din_two = b; cin = c; sub = s; in_valid = 1'b1;
      waited = 0;
      acc = 0;
      do begin
         @(negedge clk);
         acc = cur_in_ready;
         @(posedge clk);
         #1;
         waited++;
      end while (!acc && waited < 500);
      if (!acc) chk("accept_timeout", 64'(acc), 1);
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((q.size() != 0 || cur_ov) && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_empty", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0:       return 64'hFFFF_FFFF_FFFF_FFFF;
         1:       return 64'd1;
         2:       return 64'h7FFF_FFFF_7FFF_FFFF;
         3:       return 64'h8000_0000_8000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic stream(input int s, input int n, input bit randrdy);
      sel = s;
      pop_cnt = 0;
      chk_lat = !randrdy;
      out_ready = 1'b1;
      rand_rdy = randrdy;
      for (int i = 0; i < n; i++) begin
         send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if (randrdy && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      drain(3000);
      rand_rdy = 0;
      out_ready = 1'b1;
      chk("stream_pop_count", pop_cnt, n);
      if (!randrdy) chk("stream_back_to_back", pop_last - pop_first, n - 1);
   endtask

   task automatic reset_mid(input int s);
      sel = s;
      out_ready = 1'b1;
      chk_lat = 1;
      for (int i = 0; i < 3; i++) send(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pop_cnt = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      chk("mid_reset_no_output", pop_cnt, 0);
      send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
      in_valid = 1'b0;
      drain(100);
      chk("mid_reset_one_result", pop_cnt, 1);
   endtask

   typedef struct {
      int          s;
      logic [63:0] a;
      logic [63:0] b;
      logic        c;
      logic        sb;
      logic [63:0] es;
      logic        ec;
      logic        eo;
   } vec_t;

   vec_t vt[11];

   initial begin
      vt[0]  = '{0, 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
      vt[1]  = '{0, 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1};
      vt[2]  = '{0, 64'h12345678, 64'h11111111, 1'b1, 1'b0, 64'h2345678A, 1'b0, 1'b0};
      vt[3]  = '{0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0};
      vt[4]  = '{0, 64'h80000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1};
      vt[5]  = '{0, 64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0};
      vt[6]  = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
      vt[7]  = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
      vt[8]  = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vt[9]  = '{2, 64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vt[10] = '{2, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

      sel = 0;
      rst_n = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      din_one = 64'hFFFF_FFFF_FFFF_FFFF;
      din_two = 64'h1;
      cin = 1'b0;
      sub = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid_a", ov_a, 0);
      chk("rst_sum_a", sum_a, 0);
      chk("rst_cout_a", co_a, 0);
      chk("rst_ovf_a", of_a, 0);
      chk("rst_out_valid_b", ov_b, 0);
      chk("rst_sum_b", sum_b, 0);
      chk("rst_out_valid_c", ov_c, 0);
      chk("rst_sum_c", sum_c, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_out_valid_a", ov_a, 0);
      chk("idle_out_valid_b", ov_b, 0);
      chk("idle_out_valid_c", ov_c, 0);
      @(posedge clk);
      #1;

      chk_lat = 1;
      for (int i = 0; i < 11; i++) begin
         int n;
         sel = vt[i].s;
         send(vt[i].a, vt[i].b, vt[i].c, vt[i].sb);
         in_valid = 1'b0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!cur_ov && n < 20);
         chk($sformatf("vec%0d_valid", i), cur_ov, 1);
         chk($sformatf("vec%0d_sum", i), cur_sum, vt[i].es);
         chk($sformatf("vec%0d_cout", i), cur_co, vt[i].ec);
         chk($sformatf("vec%0d_ovf", i), cur_of, vt[i].eo);
         @(posedge clk);
         #1;
      end

      for (int s = 0; s < 3; s++) begin
         stream(s, 64, 1'b1);
         stream(s, 64, 1'b0);
      end

      reset_mid(0);
      reset_mid(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
